activation_ctrl: RTL and testbench
==================================

Name: activation_ctrl

Overview:
- Sequences the activation unit for one output tile of the systolic matmul.
- Buffers result rows from the matmul output in a small FIFO and issues them one row per cycle to the activation unit's data/available interface.
- Counts rows returned by the activation unit, bounds rows in flight, and drives enable_activation.
- Pulses done once the programmed row count has passed through the activation unit.

Parameters:
- DWIDTH, 8, bits per element (matches `DWIDTH)
- MAT_MUL_SIZE, 4, elements per row (matches `MAT_MUL_SIZE)
- FIFO_DEPTH, 4, row buffer entries, power of 2, ≥2
- MAX_INFLIGHT, 4, max rows issued but not yet returned
- CNT_WIDTH, 8, width of row counters

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- start  in  1  single-cycle start pulse, sampled only in IDLE
- num_rows  in  CNT_WIDTH  rows in tile, latched on start
- mm_valid  in  1  matmul row valid
- mm_data  in  MAT_MUL_SIZE*DWIDTH  matmul row
- mm_ready  out  1  row accepted when mm_valid&&mm_ready
- enable_activation  out  1  to activation unit
- act_in_data_available  out  1  row valid to activation unit
- act_inp_data  out  MAT_MUL_SIZE*DWIDTH  row to activation unit
- act_out_data_available  in  1  activation output valid
- act_out_data  in  MAT_MUL_SIZE*DWIDTH  activation output row
- act_done  in  1  activation unit done
- out_ready  in  1  downstream can take new rows (gates issue only)
- out_valid  out  1  = act_out_data_available while RUN/DRAIN
- out_data  out  MAT_MUL_SIZE*DWIDTH  = act_out_data
- done  out  1  one-cycle completion pulse
- err  out  1  sticky protocol error

Behaviour:
- Reset (reset==0 at posedge): FSM=IDLE; FIFO empty; all counters 0; all outputs 0; act_inp_data=0. Reset mid-tile aborts; in-flight rows are discarded; out_valid is forced 0.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start with num_rows!=0: latch num_rows, clear counters and err, go RUN.
  - start with num_rows==0: go DONE directly.
- RUN:
  - enable_activation=1.
  - mm_ready = !fifo_full && (accepted<num_rows).
  - Issue condition: fifo nonempty && out_ready && (issued-received)<MAX_INFLIGHT && issued<num_rows. On issue: pop, issued++.
  - When issued reaches num_rows, go DRAIN.
- DRAIN:
  - enable_activation=1, mm_ready=0.
  - When received==num_rows && act_done, go DONE. The last receive and the transition may occur in the same cycle.
- DONE:
  - done=1 for exactly one cycle, enable_activation=0, then go IDLE.
- start outside IDLE is ignored.
- Issue timing:
  - The issue decision in cycle c registers act_in_data_available=1 and act_inp_data=popped row in cycle c+1; otherwise act_in_data_available=0 and act_inp_data holds its value.
  - Minimum latency from mm handshake (cycle t) to act_in_data_available is t+2. A push is visible for pop in the next cycle; there is no same-cycle bypass.
- FIFO:
  - Push and pop in the same cycle are allowed at any occupancy except push when full (blocked by mm_ready).
  - Pointers are log2(FIFO_DEPTH) bits, wrap naturally; an extra bit distinguishes full from empty.
- Counters:
  - accepted, issued and received are CNT_WIDTH bits; none exceeds num_rows.
  - received increments on act_out_data_available in RUN/DRAIN.
  - An issue and a receive in the same cycle leave in-flight unchanged.
- err sets, and holds until the next accepted start, when either:
  - act_out_data_available occurs while issued==received, or
  - act_out_data_available occurs in IDLE/DONE.
  - The row is dropped (out_valid=0).
- out_ready low stops new issues only. Rows already in flight (≤MAX_INFLIGHT) still emerge on out_valid; downstream must absorb them.

Test Plan:
- Pass-through activation unit (combinational, act_done=1), num_rows=4, mm_valid held high, out_ready=1:
  - mm_ready high for 4 accepts.
  - act_in_data_available at t+2..t+5, out_data equals input rows in order.
  - done pulses one cycle after 4th out_valid; enable_activation 1 from RUN through DRAIN.
- num_rows=8, out_ready=0 from start: FIFO fills after 4 accepts, mm_ready drops. Raising out_ready drains all 8 in order, then done.
- Activation model with 6-cycle latency, MAX_INFLIGHT=4, num_rows=10:
  - Never more than 4 rows outstanding.
  - Issue stalls until returns arrive; done after 10th return.
- start with num_rows=0: done pulses the cycle after start; mm_ready and act_in_data_available stay 0.
- Mid-tile reset after 3 of 6 rows:
  - All outputs 0 next cycle, FIFO empty.
  - A new start with num_rows=2 completes cleanly with err=0.
- Spurious act_out_data_available in IDLE → err=1 and stays 1; start then clears it. A second start asserted during RUN is ignored and the row count is unchanged.

Source files
------------

// File: rtl/activation_ctrl_if.sv
// activation_ctrl_if: matmul row stream (valid/ready) into activation_ctrl.
// master = matmul side (drives mm_valid/mm_data), slave = controller side (drives mm_ready).
interface activation_ctrl_if #(
  parameter int DWIDTH       = 8,
  parameter int MAT_MUL_SIZE = 4
);
  logic                           mm_valid;
  logic [MAT_MUL_SIZE*DWIDTH-1:0] mm_data;
  logic                           mm_ready;

  modport master (
    output mm_valid,
    output mm_data,
    input  mm_ready
  );

  modport slave (
    input  mm_valid,
    input  mm_data,
    output mm_ready
  );
endinterface

// File: rtl/activation_ctrl.sv
// activation_ctrl: buffers matmul result rows, feeds the activation unit one row per cycle,
// bounds rows in flight and pulses done when a tile's rows have all come back.
// Ports:
//   clk, reset (sync, active-low)
//   start, num_rows          tile start pulse and row count (latched in IDLE)
//   mm (slave)               matmul row stream: mm_valid, mm_data, mm_ready
//   enable_activation        high in RUN/DRAIN
//   act_in_data_available    registered row-valid to activation unit
//   act_inp_data             registered row to activation unit
//   act_out_data_available   activation unit row-valid back
//   act_out_data             activation unit row back
//   act_done                 activation unit done, required to leave DRAIN
//   out_ready                downstream may take new rows (gates issue only)
//   out_valid, out_data      returned rows to downstream
//   done                     one-cycle tile completion pulse
//   err                      sticky protocol error
module activation_ctrl #(
  parameter int DWIDTH       = 8,
  parameter int MAT_MUL_SIZE = 4,
  parameter int FIFO_DEPTH   = 4,
  parameter int MAX_INFLIGHT = 4,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [CNT_WIDTH-1:0]           num_rows,
  activation_ctrl_if.slave               mm,
  output logic                           enable_activation,
  output logic                           act_in_data_available,
  output logic [MAT_MUL_SIZE*DWIDTH-1:0] act_inp_data,
  input  logic                           act_out_data_available,
  input  logic [MAT_MUL_SIZE*DWIDTH-1:0] act_out_data,
  input  logic                           act_done,
  input  logic                           out_ready,
  output logic                           out_valid,
  output logic [MAT_MUL_SIZE*DWIDTH-1:0] out_data,
  output logic                           done,
  output logic                           err
);
  localparam int RW = MAT_MUL_SIZE * DWIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] rows_q, rows_d;
  logic [CNT_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_WIDTH-1:0] iss_q, iss_d;
  logic [CNT_WIDTH-1:0] rcv_q, rcv_d;
  logic [PW-1:0]        wptr_q, wptr_d;
  logic [PW-1:0]        rptr_q, rptr_d;
  logic                 err_q, err_d;
  logic                 avail_q, avail_d;
  logic [RW-1:0]        inp_q, inp_d;
  logic [RW-1:0]        mem_q [FIFO_DEPTH];

  logic                 empty, full, busy;
  logic                 push, pop, rx, rx_bad;
  logic [CNT_WIDTH-1:0] inflight;

  assign empty    = wptr_q == rptr_q;
  assign full     = (wptr_q[AW] != rptr_q[AW]) &&
                    (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign busy     = (state_q == RUN) || (state_q == DRAIN);
  assign inflight = iss_q - rcv_q;

  assign mm.mm_ready = (state_q == RUN) && !full && (acc_q < rows_q);
  assign push        = mm.mm_valid && mm.mm_ready;

  assign pop = (state_q == RUN) && !empty && out_ready &&
               (inflight < CNT_WIDTH'(MAX_INFLIGHT)) &&
               (iss_q < rows_q);

  // A return is only legal while busy with something outstanding;
  // anything else is flagged and dropped.
  assign rx     = busy && act_out_data_available && (inflight != '0);
  assign rx_bad = act_out_data_available && !rx;

  assign enable_activation     = busy;
  assign act_in_data_available = avail_q;
  assign act_inp_data          = inp_q;
  assign out_valid             = rx;
  assign out_data              = act_out_data;
  assign done                  = state_q == DONE;
  assign err                   = err_q;

  always_comb begin
    state_d = state_q;
    rows_d  = rows_q;
    acc_d   = acc_q + CNT_WIDTH'(push);
    iss_d   = iss_q + CNT_WIDTH'(pop);
    rcv_d   = rcv_q + CNT_WIDTH'(rx);
    wptr_d  = wptr_q + PW'(push);
    rptr_d  = rptr_q + PW'(pop);
    err_d   = err_q | rx_bad;
    avail_d = pop;
    inp_d   = pop ? mem_q[rptr_q[AW-1:0]] : inp_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          rows_d  = num_rows;
          acc_d   = '0;
          iss_d   = '0;
          rcv_d   = '0;
          wptr_d  = '0;
          rptr_d  = '0;
          err_d   = rx_bad;
          state_d = (num_rows != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (pop && (iss_d == rows_q)) state_d = DRAIN;
      end
      DRAIN: begin
        // rcv_d includes this cycle's return
        if ((rcv_d == rows_q) && act_done) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      rows_q  <= '0;
      acc_q   <= '0;
      iss_q   <= '0;
      rcv_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      err_q   <= 1'b0;
      avail_q <= 1'b0;
      inp_q   <= '0;
    end else begin
      state_q <= state_d;
      rows_q  <= rows_d;
      acc_q   <= acc_d;
      iss_q   <= iss_d;
      rcv_q   <= rcv_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      err_q   <= err_d;
      avail_q <= avail_d;
      inp_q   <= inp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= mm.mm_data;
  end
endmodule

// File: tb/tb_activation_ctrl.sv
// tb_activation_ctrl: vector table, directed tiles and random tiles for activation_ctrl.
// Activation unit is a delay line of programmable latency (0 = combinational).
module tb_activation_ctrl;
  localparam int DW = 8;
  localparam int MS = 4;
  localparam int RW = DW * MS;
  localparam int CW = 8;
  localparam logic [RW-1:0] BASE = 32'hC0DE_0000;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] num_rows = '0;
  logic          out_ready = 1'b0;
  logic          act_done = 1'b1;
  logic          spur = 1'b0;
  logic          ena, act_ida, act_oda, out_valid, done, err;
  logic [RW-1:0] act_inp, act_od, out_data;
  int            act_lat = 0;
  logic [2:0]    li;
  int            total = 0;
  int            passed = 0;

  activation_ctrl_if #(.DWIDTH(DW), .MAT_MUL_SIZE(MS)) mm_if ();

  activation_ctrl #(
    .DWIDTH(DW), .MAT_MUL_SIZE(MS), .FIFO_DEPTH(4),
    .MAX_INFLIGHT(4), .CNT_WIDTH(CW)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .start                  (start),
    .num_rows               (num_rows),
    .mm                     (mm_if),
    .enable_activation      (ena),
    .act_in_data_available  (act_ida),
    .act_inp_data           (act_inp),
    .act_out_data_available (act_oda),
    .act_out_data           (act_od),
    .act_done               (act_done),
    .out_ready              (out_ready),
    .out_valid              (out_valid),
    .out_data               (out_data),
    .done                   (done),
    .err                    (err)
  );

  always #5 clk = ~clk;

  logic          pv [8];
  logic [RW-1:0] pd [8];

  always @(posedge clk) begin
    pd[0] <= act_inp;
    for (int i = 1; i < 8; i++) pd[i] <= pd[i-1];
    if (!reset) begin
      for (int i = 0; i < 8; i++) pv[i] <= 1'b0;
    end else begin
      pv[0] <= act_ida;
      for (int i = 1; i < 8; i++) pv[i] <= pv[i-1];
    end
  end

  assign li = 3'(act_lat - 1);

  always_comb begin
    act_oda = act_ida | spur;
    act_od  = act_inp;
    if (act_lat != 0) begin
      act_oda = pv[li] | spur;
      act_od  = pd[li];
    end
  end

  task automatic check(input string name, input longint act,
                       input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Runs one tile against a scoreboard: rows must reach the activation unit
  // and downstream in acceptance order, no sooner than 2 cycles after
  // acceptance, with at most 4 outstanding; done follows the last return.
  task automatic run_tile(input string tag, input int n, input int lat,
                          input int or_hold, input int or_pct,
                          input int mv_pct, input int restart_at,
                          output int acc_pre, output int max_inf);
    logic [RW-1:0] qi[$];
    logic [RW-1:0] qo[$];
    int qa[$];
    int acc = 0, iss = 0, rcv = 0, cyc = 0;
    int done_cyc = -1, last_out = -2;
    int b_in = 0, b_out = 0, b_lat = 0, b_inf = 0;
    int b_mmr = 0, b_en = 0, b_err = 0;
    acc_pre = -1;
    max_inf = 0;
    start = 1'b0;
    mm_if.mm_valid = 1'b0;
    out_ready = 1'b0;
    repeat (9) @(posedge clk);
    act_lat = lat;
    #1;
    start = 1'b1;
    num_rows = CW'(n);
    @(posedge clk);
    #1;
    while (done_cyc < 0 && cyc < 3000) begin
      start = (cyc == restart_at);
      num_rows = start ? 8'd7 : 8'hFF;
      mm_if.mm_valid = $urandom_range(0, 99) < mv_pct;
      mm_if.mm_data = $urandom();
      out_ready = (cyc >= or_hold) && ($urandom_range(0, 99) < or_pct);
      @(negedge clk);
      if (act_ida) begin
        if (iss == 0) acc_pre = acc;
        if (qi.size() == 0) b_in++;
        else begin
          if (qi.pop_front() != act_inp) b_in++;
          if (cyc < qa.pop_front() + 2) b_lat++;
        end
        iss++;
      end
      if (out_valid) begin
        if (qo.size() == 0) b_out++;
        else if (qo.pop_front() != out_data) b_out++;
        rcv++;
        last_out = cyc;
      end
      if (iss - rcv > max_inf) max_inf = iss - rcv;
      if (iss - rcv > 4) b_inf++;
      if (mm_if.mm_valid && mm_if.mm_ready) begin
        if (acc >= n) b_mmr++;
        qi.push_back(mm_if.mm_data);
        qo.push_back(mm_if.mm_data);
        qa.push_back(cyc);
        acc++;
      end
      if (done) begin
        done_cyc = cyc;
        if (ena) b_en++;
      end else if (!ena) b_en++;
      if (err) b_err++;
      @(posedge clk);
      #1;
      cyc++;
    end
    start = 1'b0;
    mm_if.mm_valid = 1'b0;
    @(negedge clk);
    check({tag, " done seen"}, 64'(done_cyc >= 0), 1);
    check({tag, " accepted"}, 64'(acc), 64'(n));
    check({tag, " issued"}, 64'(iss), 64'(n));
    check({tag, " returned"}, 64'(rcv), 64'(n));
    check({tag, " issue order"}, 64'(b_in), 0);
    check({tag, " out order"}, 64'(b_out), 0);
    check({tag, " issue latency"}, 64'(b_lat), 0);
    check({tag, " inflight bound"}, 64'(b_inf), 0);
    check({tag, " mm_ready bound"}, 64'(b_mmr), 0);
    check({tag, " enable"}, 64'(b_en), 0);
    check({tag, " err clear"}, 64'(b_err), 0);
    check({tag, " done timing"}, 64'(done_cyc), 64'(last_out + 1));
    check({tag, " done one cycle"}, 64'({done, ena}), 0);
  endtask

  typedef struct {
    logic          st;
    logic [CW-1:0] n;
    logic          mv;
    logic          ordy;
    logic [5:0]    exp;
    int            idx;
  } vec_t;

  vec_t tbl[12];

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k, ap, mi;
    // exp = {mm_ready, enable, act_in_avail, out_valid, done, err}
    tbl[0]  = '{1'b1, 8'd4, 1'b1, 1'b1, 6'b000000, 0};
    tbl[1]  = '{1'b0, 8'd4, 1'b1, 1'b1, 6'b110000, 0};
    tbl[2]  = '{1'b0, 8'd4, 1'b1, 1'b1, 6'b110000, 0};
    tbl[3]  = '{1'b0, 8'd4, 1'b1, 1'b1, 6'b111100, 0};
    tbl[4]  = '{1'b0, 8'd4, 1'b1, 1'b1, 6'b111100, 1};
    tbl[5]  = '{1'b0, 8'd4, 1'b1, 1'b1, 6'b011100, 2};
    tbl[6]  = '{1'b0, 8'd4, 1'b1, 1'b1, 6'b011100, 3};
    tbl[7]  = '{1'b0, 8'd4, 1'b1, 1'b1, 6'b000010, 0};
    tbl[8]  = '{1'b0, 8'd4, 1'b1, 1'b1, 6'b000000, 0};
    tbl[9]  = '{1'b1, 8'd0, 1'b1, 1'b1, 6'b000000, 0};
    tbl[10] = '{1'b0, 8'd0, 1'b1, 1'b1, 6'b000010, 0};
    tbl[11] = '{1'b0, 8'd0, 1'b1, 1'b1, 6'b000000, 0};

    mm_if.mm_valid = 1'b0;
    mm_if.mm_data = '0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset flags",
          64'({mm_if.mm_ready, ena, act_ida, out_valid, done, err}), 0);
    check("reset act_inp_data", 64'(act_inp), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    k = 0;
    for (int i = 0; i < 12; i++) begin
      start = tbl[i].st;
      num_rows = tbl[i].n;
      mm_if.mm_valid = tbl[i].mv;
      out_ready = tbl[i].ordy;
      mm_if.mm_data = BASE + RW'(k);
      @(negedge clk);
      check($sformatf("vec%0d flags", i),
            64'({mm_if.mm_ready, ena, act_ida, out_valid, done, err}),
            64'(tbl[i].exp));
      if (tbl[i].exp[2])
        check($sformatf("vec%0d out_data", i), 64'(out_data),
              64'(BASE + RW'(tbl[i].idx)));
      if (mm_if.mm_valid && mm_if.mm_ready) k++;
      @(posedge clk);
      #1;
    end

    run_tile("stall", 8, 0, 20, 100, 100, -1, ap, mi);
    check("stall accepts before issue", 64'(ap), 4);

    run_tile("lat6", 10, 6, 0, 100, 100, -1, ap, mi);
    check("lat6 peak inflight", 64'(mi), 4);

    repeat (9) @(posedge clk);
    act_lat = 6;
    #1;
    start = 1'b1;
    num_rows = 8'd6;
    mm_if.mm_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    k = 0;
    for (int c = 0; c < 50 && k < 3; c++) begin
      mm_if.mm_data = BASE + RW'(c);
      @(negedge clk);
      if (mm_if.mm_valid && mm_if.mm_ready) k++;
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    mm_if.mm_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("mid reset flags",
          64'({mm_if.mm_ready, ena, act_ida, out_valid, done, err}), 0);
    check("mid reset act_inp_data", 64'(act_inp), 0);
    run_tile("after reset", 2, 0, 0, 100, 100, -1, ap, mi);

    @(posedge clk);
    #1;
    spur = 1'b1;
    @(negedge clk);
    check("spurious dropped", 64'(out_valid), 0);
    @(posedge clk);
    #1;
    spur = 1'b0;
    @(negedge clk);
    check("err set", 64'(err), 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("err sticky", 64'(err), 1);
    run_tile("restart ignored", 3, 0, 0, 100, 100, 2, ap, mi);

    for (int t = 0; t < 8; t++)
      run_tile($sformatf("rand%0d", t), $urandom_range(1, 20),
               $urandom_range(0, 7), $urandom_range(0, 4),
               $urandom_range(30, 100), $urandom_range(30, 100),
               $urandom_range(0, 12), ap, mi);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
